uart_periph: RTL and testbench

- 8N1 UART peripheral for one 256-byte slot of the 8-slot peripheral interconnect. Target slot: periph0, 0x12000000-0x120000FF.
- Register access uses the interconnect's per-slot bus: 8-bit address, 32-bit data, byte-lane write strobes, read strobe.
- Drives one interrupt line into interrupt-controller input intr0.
- TX path: holding register plus shift register. RX path: single holding register with overflow and framing-error flags.

---
 rtl/uart_periph_pkg.sv | 37 +++
 rtl/uart_periph_bit_timer.sv | 51 +++++
 rtl/uart_periph.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_periph_pkg.sv
// Shared definitions for the uart_periph slot: register offsets, STATUS/CTRL
// bit positions, FSM state encodings and the bit-period helper.
package uart_defs;

   localparam logic [7:0] UART_STATUS = 8'h00;
   localparam logic [7:0] UART_DATA   = 8'h04;
   localparam logic [7:0] UART_CTRL   = 8'h08;

   localparam int ST_RX_READY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_TX_BUSY  = 2;
   localparam int ST_RX_OVF   = 3;
   localparam int ST_RX_FERR  = 4;

   localparam int CTRL_RX_IE = 0;
   localparam int CTRL_TX_IE = 1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Clocks per serial bit, truncated
   function automatic int calc_bit_div(input int clk_khz, input int baud);
      return (clk_khz * 1000) / baud;
   endfunction

endpackage

// File: rtl/uart_periph_bit_timer.sv
// Bit-period down-counter shared by the TX and RX paths. A full load gives a
// tick BIT_DIV clocks later, a half load gives one after BIT_DIV/2 clocks;
// after each tick the counter rewinds to a full period on its own.
module uart_bit_timer #(
   parameter int BIT_DIV = 106
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic half_load_i,
   output logic tick_o
);

   localparam int               CNT_W     = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((BIT_DIV / 2) - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             tick_r;

   // Next count: explicit loads win, otherwise count down and wrap to a full period
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (load_i) begin
         cnt_nxt_s = FULL_LOAD;
      end else if (half_load_i) begin
         cnt_nxt_s = HALF_LOAD;
      end else if (cnt_r == CNT_ZERO) begin
         cnt_nxt_s = FULL_LOAD;
      end else begin
         cnt_nxt_s = cnt_r - CNT_ONE;
      end
   end

   // Count register and registered tick (high while the count sits at zero)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r  <= FULL_LOAD;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == CNT_ZERO);
      end
   end

   assign tick_o = tick_r;

endmodule

// File: rtl/uart_periph.sv
// 8N1 UART peripheral for one 256-byte interconnect slot. TX uses a holding
// register feeding a shifter; RX has a single holding register with overflow
// and framing-error flags. One level interrupt combines RX-ready and TX-empty.
module uart_periph
   import uart_defs::*;
#(
   parameter int CLK_KHZ   = 12288,
   parameter int UART_BAUD = 115200
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        intr_o,
   input  logic [7:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic [3:0]  wr_i,
   input  logic        rd_i,
   input  logic        rxd_i,
   output logic        txd_o
);

   localparam int BIT_DIV = calc_bit_div(CLK_KHZ, UART_BAUD);

   if (BIT_DIV < 4) begin : g_bit_div_check
      $error("uart_periph: BIT_DIV must be at least 4");
   end

   // Bus decode
   logic wr_status_s, wr_data_s, wr_ctrl_s, rd_pop_s, unused_s;
   assign wr_status_s = wr_i[0] & (addr_i == UART_STATUS);
   assign wr_data_s   = wr_i[0] & (addr_i == UART_DATA);
   assign wr_ctrl_s   = wr_i[0] & (addr_i == UART_CTRL);
   assign rd_pop_s    = rd_i & (addr_i == UART_DATA);
   assign unused_s    = ^{data_i[31:8], wr_i[3:1]};

   // ---------------- TX path ----------------
   tx_state_e   tx_state_r, tx_next_s;
   logic [7:0]  tx_hold_r, tx_shift_r;
   logic [2:0]  tx_bit_r;
   logic        tx_full_r, txd_r, txd_s;
   logic        tx_tick_s, tx_xfer_s, tx_tmr_load_s, tx_shift_en_s;
   logic        tx_accept_s, tx_busy_s;

   uart_bit_timer #(.BIT_DIV(BIT_DIV)) u_tx_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (tx_tmr_load_s),
      .half_load_i (1'b0),
      .tick_o      (tx_tick_s)
   );

   assign tx_busy_s = (tx_state_r != TX_IDLE);
   // A write is taken if the holding register is empty once this cycle's transfer is done
   assign tx_accept_s = wr_data_s & (~tx_full_r | tx_xfer_s);

   // TX state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_state_r <= TX_IDLE;
      end else begin
         tx_state_r <= tx_next_s;
      end
   end

   // TX next state; a pending byte after STOP goes straight to START
   always_comb begin
      tx_next_s = tx_state_r;
      case (tx_state_r)
         TX_IDLE:  if (tx_full_r) tx_next_s = TX_START; else tx_next_s = TX_IDLE;
         TX_START: if (tx_tick_s) tx_next_s = TX_DATA;  else tx_next_s = TX_START;
         TX_DATA:  if (tx_tick_s && (tx_bit_r == 3'd7)) tx_next_s = TX_STOP;
                   else tx_next_s = TX_DATA;
         TX_STOP:  if (tx_tick_s) tx_next_s = tx_full_r ? TX_START : TX_IDLE;
                   else tx_next_s = TX_STOP;
         default:  tx_next_s = TX_IDLE;
      endcase
   end

   // TX outputs: line level, holding-to-shifter transfer, timer restart, shift enable
   always_comb begin
      txd_s         = 1'b1;
      tx_xfer_s     = 1'b0;
      tx_tmr_load_s = 1'b0;
      tx_shift_en_s = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            tx_xfer_s     = tx_full_r;
            tx_tmr_load_s = tx_full_r;
         end
         TX_START: txd_s = 1'b0;
         TX_DATA: begin
            txd_s         = tx_shift_r[0];
            tx_shift_en_s = tx_tick_s;
         end
         TX_STOP:  tx_xfer_s = tx_tick_s & tx_full_r;
         default:  txd_s = 1'b1;
      endcase
   end

   // TX datapath: holding register, shifter, bit count and registered line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_hold_r  <= 8'h00;
         tx_full_r  <= 1'b0;
         tx_shift_r <= 8'h00;
         tx_bit_r   <= 3'd0;
         txd_r      <= 1'b1;
      end else begin
         if (tx_accept_s) begin
            tx_hold_r <= data_i[7:0];
            tx_full_r <= 1'b1;
         end else if (tx_xfer_s) begin
            tx_full_r <= 1'b0;
         end
         if (tx_xfer_s) begin
            tx_shift_r <= tx_hold_r;
            tx_bit_r   <= 3'd0;
         end else if (tx_shift_en_s) begin
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bit_r   <= tx_bit_r + 3'd1;
         end
         txd_r <= txd_s;
      end
   end

   // ---------------- RX path ----------------
   rx_state_e   rx_state_r, rx_next_s;
   logic [1:0]  rx_sync_r;
   logic        rx_prev_r, rx_line_s, rx_fall_s, rx_tick_s;
   logic [7:0]  rx_shift_r, rx_byte_r;
   logic [2:0]  rx_bit_r;
   logic        rx_ready_r, rx_ovf_r, rx_ferr_r;
   logic        rx_half_load_s, rx_sample_s, rx_done_s, rx_ferr_set_s;

   uart_bit_timer #(.BIT_DIV(BIT_DIV)) u_rx_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (1'b0),
      .half_load_i (rx_half_load_s),
      .tick_o      (rx_tick_s)
   );

   assign rx_line_s = rx_sync_r[1];
   assign rx_fall_s = rx_prev_r & ~rx_line_s;

   // Two-flop synchronizer plus previous-level flop for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_sync_r <= 2'b11;
         rx_prev_r <= 1'b1;
      end else begin
         rx_sync_r <= {rx_sync_r[0], rxd_i};
         rx_prev_r <= rx_line_s;
      end
   end

   // RX state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_state_r <= RX_IDLE;
      end else begin
         rx_state_r <= rx_next_s;
      end
   end

   // RX next state; a start bit that is high at mid-bit is treated as a glitch
   always_comb begin
      rx_next_s = rx_state_r;
      case (rx_state_r)
         RX_IDLE:  if (rx_fall_s) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
         RX_START: if (rx_tick_s) rx_next_s = rx_line_s ? RX_IDLE : RX_DATA;
                   else rx_next_s = RX_START;
         RX_DATA:  if (rx_tick_s && (rx_bit_r == 3'd7)) rx_next_s = RX_STOP;
                   else rx_next_s = RX_DATA;
         RX_STOP:  if (rx_tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP;
         default:  rx_next_s = RX_IDLE;
      endcase
   end

   // RX outputs: half-period timer start, bit-centre sampling, frame outcome
   always_comb begin
      rx_half_load_s = 1'b0;
      rx_sample_s    = 1'b0;
      rx_done_s      = 1'b0;
      rx_ferr_set_s  = 1'b0;
      case (rx_state_r)
         RX_IDLE:  rx_half_load_s = rx_fall_s;
         RX_START: rx_sample_s    = 1'b0;
         RX_DATA:  rx_sample_s    = rx_tick_s;
         RX_STOP: begin
            rx_done_s     = rx_tick_s & rx_line_s;
            rx_ferr_set_s = rx_tick_s & ~rx_line_s;
         end
         default:  rx_sample_s = 1'b0;
      endcase
   end

   // RX shifter and holding register; a same-edge pop makes room for the new byte
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_shift_r <= 8'h00;
         rx_bit_r   <= 3'd0;
         rx_byte_r  <= 8'h00;
         rx_ready_r <= 1'b0;
      end else begin
         if (rx_half_load_s) begin
            rx_bit_r <= 3'd0;
         end else if (rx_sample_s) begin
            rx_shift_r <= {rx_line_s, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
         end
         if (rx_done_s && (!rx_ready_r || rd_pop_s)) begin
            rx_byte_r  <= rx_shift_r;
            rx_ready_r <= 1'b1;
         end else if (rd_pop_s) begin
            rx_ready_r <= 1'b0;
         end
      end
   end

   // Sticky error flags; a set on the same edge as a software clear wins
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_ovf_r  <= 1'b0;
         rx_ferr_r <= 1'b0;
      end else begin
         if (rx_done_s && rx_ready_r && !rd_pop_s) begin
            rx_ovf_r <= 1'b1;
         end else if (wr_status_s && data_i[ST_RX_OVF]) begin
            rx_ovf_r <= 1'b0;
         end
         if (rx_ferr_set_s) begin
            rx_ferr_r <= 1'b1;
         end else if (wr_status_s && data_i[ST_RX_FERR]) begin
            rx_ferr_r <= 1'b0;
         end
      end
   end

   // ---------------- Control, read-back, interrupt ----------------
   logic        rx_ie_r, tx_ie_r, intr_r;
   logic [31:0] data_r;

   // Interrupt enable register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_ie_r <= 1'b0;
         tx_ie_r <= 1'b0;
      end else if (wr_ctrl_s) begin
         rx_ie_r <= data_i[CTRL_RX_IE];
         tx_ie_r <= data_i[CTRL_TX_IE];
      end
   end

   // Registered read data, held between reads
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_r <= 32'h0000_0000;
      end else if (rd_i) begin
         case (addr_i)
            UART_STATUS: data_r <= {27'd0, rx_ferr_r, rx_ovf_r, tx_busy_s, tx_full_r, rx_ready_r};
            UART_DATA:   data_r <= {24'd0, rx_byte_r};
            UART_CTRL:   data_r <= {30'd0, tx_ie_r, rx_ie_r};
            default:     data_r <= 32'h0000_0000;
         endcase
      end
   end

   // Level interrupt: byte waiting, or transmitter completely drained
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         intr_r <= 1'b0;
      end else begin
         intr_r <= (rx_ready_r & rx_ie_r) | (~tx_full_r & ~tx_busy_s & tx_ie_r);
      end
   end

   assign data_o = data_r;
   assign intr_o = intr_r;
   assign txd_o  = txd_r;

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: directed scenarios plus randomized RX
// and TX traffic, checked against a register-level model of the peripheral.
module tb_uart_periph;
   import uart_defs::*;

   localparam int CLK_KHZ   = 12288;
   localparam int UART_BAUD = 115200;
   localparam int BD        = (CLK_KHZ * 1000) / UART_BAUD;

   logic        clk = 1'b0;
   logic        rst_i, intr_o, rd_i, rxd_i, txd_o;
   logic [7:0]  addr_i;
   logic [31:0] data_i, data_o;
   logic [3:0]  wr_i;

   uart_periph #(.CLK_KHZ(CLK_KHZ), .UART_BAUD(UART_BAUD)) dut (
      .clk_i(clk), .rst_i(rst_i), .intr_o(intr_o), .addr_i(addr_i),
      .data_i(data_i), .data_o(data_o), .wr_i(wr_i), .rd_i(rd_i),
      .rxd_i(rxd_i), .txd_o(txd_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Register-level model
   bit         m_rx_ready, m_ovf, m_ferr, m_rx_ie, m_tx_ie;
   logic [7:0] m_rx_byte;

   function automatic logic [31:0] exp_status(input bit full, input bit busy);
      return {27'd0, m_ferr, m_ovf, busy, full, m_rx_ready};
   endfunction

   function automatic logic exp_intr_idle_tx();
      return (m_rx_ready & m_rx_ie) | m_tx_ie;
   endfunction

   task automatic model_rx(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) m_ferr = 1'b1;
      else if (m_rx_ready) m_ovf = 1'b1;
      else begin
         m_rx_byte  = b;
         m_rx_ready = 1'b1;
      end
   endtask

   int last_wr_cyc;

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      addr_i = a; data_i = d; wr_i = 4'b0001;
      @(posedge clk); #1;
      last_wr_cyc = cyc;
      wr_i = 4'b0000;
      if (a == UART_STATUS) begin
         if (d[3]) m_ovf = 1'b0;
         if (d[4]) m_ferr = 1'b0;
      end
      if (a == UART_CTRL) begin
         m_rx_ie = d[0];
         m_tx_ie = d[1];
      end
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      addr_i = a; rd_i = 1'b1;
      @(posedge clk); #1;
      rd_i = 1'b0;
      d = data_o;
      if (a == UART_DATA) m_rx_ready = 1'b0;
   endtask

   // DATA writes on consecutive clocks, byte i taken from bytes[8*i +: 8]
   task automatic write_burst(input int n, input logic [23:0] bytes);
      @(posedge clk); #1;
      addr_i = UART_DATA; wr_i = 4'b0001;
      for (int i = 0; i < n; i++) begin
         data_i = {24'd0, bytes[8*i +: 8]};
         @(posedge clk); #1;
         if (i == 0) last_wr_cyc = cyc;
      end
      wr_i = 4'b0000;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      @(posedge clk); #1;
      rxd_i = 1'b0;
      repeat (BD) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rxd_i = b[i];
         repeat (BD) @(posedge clk);
         #1;
      end
      rxd_i = stop_ok;
      repeat (BD) @(posedge clk);
      #1;
      rxd_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      model_rx(b, stop_ok);
   endtask

   // TX line monitor: captures whole frames cycle by cycle
   logic [7:0] tx_got_q[$];
   int         tx_start_q[$];
   bit         mon_en = 1'b0;
   logic       prev_txd;
   logic       line_a [10*BD];
   int         mon_t0, mon_errs;
   logic [7:0] mon_byte;

   initial begin
      prev_txd = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (mon_en && prev_txd && (txd_o == 1'b0)) begin
            mon_t0 = cyc;
            line_a[0] = txd_o;
            for (int i = 1; i < 10*BD; i++) begin
               @(posedge clk); #1;
               line_a[i] = txd_o;
            end
            mon_errs = 0;
            for (int k = 0; k < 10; k++) begin
               if (line_a[k*BD] !== line_a[k*BD + BD/2]) mon_errs++;
               if (line_a[k*BD + BD - 1] !== line_a[k*BD + BD/2]) mon_errs++;
            end
            for (int k = 0; k < 8; k++) mon_byte[k] = line_a[(k+1)*BD + BD/2];
            check_value("tx_start_bit", {31'd0, line_a[BD/2]}, 32'd0);
            check_value("tx_stop_bit", {31'd0, line_a[9*BD + BD/2]}, 32'd1);
            check_value("tx_bit_edges", mon_errs, 32'd0);
            tx_got_q.push_back(mon_byte);
            tx_start_q.push_back(mon_t0);
         end
         prev_txd = txd_o;
      end
   end

   task automatic wait_tx(input int n, input int budget);
      int k;
      k = 0;
      while ((tx_got_q.size() < n) && (k < budget)) begin
         @(posedge clk); #1;
         k++;
      end
      check_value("tx_frame_count", tx_got_q.size(), n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] rd_v;
   logic [7:0]  rb;
   logic [23:0] tb_bytes;
   bit          ok;
   int          n, acc;

   initial begin
      rst_i = 1'b1; rxd_i = 1'b1; wr_i = 4'b0000; rd_i = 1'b0;
      addr_i = 8'h00; data_i = 32'd0;
      m_rx_ready = 0; m_ovf = 0; m_ferr = 0; m_rx_ie = 0; m_tx_ie = 0; m_rx_byte = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_txd", {31'd0, txd_o}, 32'd1);
      check_value("rst_intr", {31'd0, intr_o}, 32'd0);
      check_value("rst_data", data_o, 32'd0);
      rst_i = 1'b0;

      // Reset in the middle of a frame of all-zero data
      bus_write(UART_DATA, 32'h00);
      repeat (300) @(posedge clk);
      #1;
      check_value("tx_mid_frame_low", {31'd0, txd_o}, 32'd0);
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      check_value("rst_async_txd", {31'd0, txd_o}, 32'd1);
      check_value("rst_async_intr", {31'd0, intr_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      bus_read(UART_STATUS, rd_v);
      check_value("rst_status", rd_v, 32'h00);
      mon_en = 1'b1;

      // Single frame timing
      bus_write(UART_DATA, 32'h55);
      repeat (20) @(posedge clk);
      bus_read(UART_STATUS, rd_v);
      check_value("tx_busy_mid", rd_v, exp_status(1'b0, 1'b1));
      wait_tx(1, 1500);
      if (tx_got_q.size() >= 1) begin
         check_value("tx_byte_55", tx_got_q[0], 32'h55);
         check_value("tx_start_latency", tx_start_q[0] - last_wr_cyc, 32'd2);
      end
      repeat (3) @(posedge clk);
      bus_read(UART_STATUS, rd_v);
      check_value("tx_idle_after", rd_v, exp_status(1'b0, 1'b0));
      tx_got_q.delete(); tx_start_q.delete();

      // Back-to-back frames, third write dropped, TX-empty interrupt
      bus_write(UART_CTRL, 32'h2);
      repeat (2) @(posedge clk);
      #1;
      check_value("intr_tx_idle", {31'd0, intr_o}, {31'd0, exp_intr_idle_tx()});
      write_burst(3, 24'h332211);
      bus_read(UART_STATUS, rd_v);
      check_value("tx_full_status", rd_v, exp_status(1'b1, 1'b1));
      repeat (1500) @(posedge clk);
      #1;
      check_value("intr_tx_busy", {31'd0, intr_o}, 32'd0);
      wait_tx(2, 1500);
      if (tx_got_q.size() >= 2) begin
         check_value("tx_b2b_first", tx_got_q[0], 32'h11);
         check_value("tx_b2b_second", tx_got_q[1], 32'h22);
         check_value("tx_no_gap", tx_start_q[1] - tx_start_q[0], 10*BD);
      end
      repeat (3) @(posedge clk);
      #1;
      check_value("intr_tx_done", {31'd0, intr_o}, 32'd1);
      repeat (3*BD) @(posedge clk);
      bus_read(UART_STATUS, rd_v);
      check_value("tx_third_dropped", rd_v, exp_status(1'b0, 1'b0));
      check_value("tx_third_count", tx_got_q.size(), 32'd2);
      tx_got_q.delete(); tx_start_q.delete();

      // RX receive with interrupt
      bus_write(UART_CTRL, 32'h1);
      send_frame(8'hA3, 1'b1);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_ready_status", rd_v, exp_status(1'b0, 1'b0));
      check_value("rx_intr", {31'd0, intr_o}, 32'd1);
      bus_read(UART_DATA, rd_v);
      check_value("rx_data_a3", rd_v, 32'h0000_00A3);
      repeat (3) @(posedge clk);
      #1;
      check_value("data_o_hold", data_o, 32'h0000_00A3);
      check_value("rx_intr_clear", {31'd0, intr_o}, 32'd0);

      // Overflow
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_ovf_status", rd_v, exp_status(1'b0, 1'b0));
      bus_read(UART_DATA, rd_v);
      check_value("rx_ovf_data", rd_v, 32'h01);
      bus_write(UART_STATUS, 32'h08);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_ovf_clear", rd_v, exp_status(1'b0, 1'b0));

      // Framing error, then a short glitch
      send_frame(8'h5A, 1'b0);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_ferr_status", rd_v, exp_status(1'b0, 1'b0));
      bus_write(UART_STATUS, 32'h10);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_ferr_clear", rd_v, exp_status(1'b0, 1'b0));
      @(posedge clk); #1;
      rxd_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rxd_i = 1'b1;
      repeat (100) @(posedge clk);
      bus_read(UART_STATUS, rd_v);
      check_value("rx_glitch_status", rd_v, exp_status(1'b0, 1'b0));
      bus_read(UART_DATA, rd_v);
      check_value("rx_glitch_data", rd_v, {24'd0, m_rx_byte});

      // Randomized RX traffic
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         bus_write(UART_CTRL, {30'd0, 2'($urandom_range(0, 3))});
         send_frame(rb, ok);
         bus_read(UART_STATUS, rd_v);
         check_value("rand_rx_status", rd_v, exp_status(1'b0, 1'b0));
         repeat (2) @(posedge clk);
         #1;
         check_value("rand_rx_intr", {31'd0, intr_o}, {31'd0, exp_intr_idle_tx()});
         if ($urandom_range(0, 1) == 1) begin
            bus_read(UART_DATA, rd_v);
            check_value("rand_rx_data", rd_v, {24'd0, m_rx_byte});
         end
         if ($urandom_range(0, 1) == 1) begin
            bus_write(UART_STATUS, {27'd0, 2'($urandom_range(0, 3)), 3'd0});
         end
      end

      // Randomized TX bursts: the holding register plus shifter take at most two
      for (int i = 0; i < 3; i++) begin
         n = $urandom_range(1, 3);
         tb_bytes = 24'($urandom);
         acc = (n < 2) ? n : 2;
         write_burst(n, tb_bytes);
         wait_tx(acc, 1200*acc + 200);
         for (int k = 0; k < acc; k++) begin
            if (tx_got_q.size() > k) check_value("rand_tx_byte", tx_got_q[k], {24'd0, tb_bytes[8*k +: 8]});
         end
         repeat (2*BD) @(posedge clk);
         bus_read(UART_STATUS, rd_v);
         check_value("rand_tx_idle", rd_v, exp_status(1'b0, 1'b0));
         tx_got_q.delete(); tx_start_q.delete();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
